// File: rtl/fpu_trace_recorder.sv
// fpu_trace_recorder: captures FPU transactions {Overflow, Error, round, Sel, Y, B, A}
// into a DEPTH-entry FIFO buffer with drop-new or overwrite-oldest full policy,
// read back one record per cycle through a registered read port.
module fpu_trace_recorder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WRAP  = 0,
  parameter int unsigned REC_W = 3*WIDTH+6
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [1:0]                 Sel,
  input  logic [1:0]                 round,
  input  logic [WIDTH-1:0]           Y,
  input  logic                       Error,
  input  logic                       Overflow,
  input  logic                       start,
  input  logic                       FIN,
  input  logic                       rd_en,
  output logic [REC_W-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       frozen,
  output logic [31:0]                txn_cnt,
  output logic [15:0]                dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      txn_q, txn_d;
  logic [15:0]      drop_q, drop_d;
  logic             frozen_q, frozen_d;
  logic             rd_valid_q, rd_valid_d;
  logic [REC_W-1:0] rd_data_q, rd_data_d;

  logic [REC_W-1:0] rec;
  logic             is_empty, is_full;
  logic             rd_acc, cap, wr_en, overwrite, lost, grow;

  assign rec      = {Overflow, Error, round, Sel, Y, B, A};
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Decide this cycle's read/capture outcome and next register values.
  // A read accepted while full frees a slot first, so a coincident capture is
  // stored normally rather than dropped or overwriting.
  always_comb begin
    rd_acc     = rd_en && !is_empty;
    cap        = start && !frozen_q;
    lost       = cap && is_full && !rd_acc;
    overwrite  = lost && (WRAP != 0);
    wr_en      = cap && (!lost || (WRAP != 0));
    grow       = wr_en && !overwrite;

    wp_d       = wr_en ? wp_q + AW'(1) : wp_q;
    rp_d       = (rd_acc || overwrite) ? rp_q + AW'(1) : rp_q;
    count_d    = count_q;
    if (grow && !rd_acc)      count_d = count_q + CW'(1);
    else if (!grow && rd_acc) count_d = count_q - CW'(1);
    txn_d      = cap ? txn_q + 32'd1 : txn_q;
    drop_d     = (lost && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    frozen_d   = frozen_q || FIN;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem_q[rp_q] : rd_data_q;
  end

  // Record storage; contents are not cleared by Reset.
  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wp_q] <= rec;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      txn_q      <= '0;
      drop_q     <= '0;
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      txn_q      <= txn_d;
      drop_q     <= drop_d;
      frozen_q   <= frozen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign frozen   = frozen_q;
  assign txn_cnt  = txn_q;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_fpu_trace_recorder.sv
// Testbench: two DEPTH=4 recorders (drop-new and ring policy) driven by the
// same stimulus, each compared every cycle against a queue-based model.
module tb_fpu_trace_recorder;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned RW = 3*W+6;
  localparam int unsigned CW = 3;

  typedef logic [RW-1:0] rec_t;

  logic         Clock = 1'b0;
  logic         Reset, Error, Overflow, start, FIN, rd_en;
  logic [W-1:0] A, B, Y;
  logic [1:0]   Sel, round;

  rec_t          rdd [2];
  logic          rdv [2];
  logic [CW-1:0] cnt [2];
  logic          emp [2];
  logic          ful [2];
  logic          frz [2];
  logic [31:0]   txn [2];
  logic [15:0]   drp [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state
  rec_t        mq [2][$];
  int unsigned m_txn [2];
  int unsigned m_drop [2];
  bit          m_frozen [2];
  rec_t        m_rd [2];
  bit          m_val [2];

  always #5 Clock = ~Clock;

  fpu_trace_recorder #(.WIDTH(W), .DEPTH(D), .WRAP(0)) d0 (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .Sel(Sel), .round(round), .Y(Y),
    .Error(Error), .Overflow(Overflow), .start(start), .FIN(FIN), .rd_en(rd_en),
    .rd_data(rdd[0]), .rd_valid(rdv[0]), .count(cnt[0]), .empty(emp[0]), .full(ful[0]),
    .frozen(frz[0]), .txn_cnt(txn[0]), .dropped(drp[0]));

  fpu_trace_recorder #(.WIDTH(W), .DEPTH(D), .WRAP(1)) d1 (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .Sel(Sel), .round(round), .Y(Y),
    .Error(Error), .Overflow(Overflow), .start(start), .FIN(FIN), .rd_en(rd_en),
    .rd_data(rdd[1]), .rd_valid(rdv[1]), .count(cnt[1]), .empty(emp[1]), .full(ful[1]),
    .frozen(frz[1]), .txn_cnt(txn[1]), .dropped(drp[1]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the specification's rules, expressed on a FIFO queue.
  task automatic model_step(input int w);
    bit   rd_ok, cap;
    rec_t r;
    if (Reset) begin
      mq[w].delete();
      m_txn[w] = 0; m_drop[w] = 0; m_frozen[w] = 1'b0;
      m_rd[w] = '0; m_val[w] = 1'b0;
      return;
    end
    r = {Overflow, Error, round, Sel, Y, B, A};
    rd_ok = rd_en && (mq[w].size() > 0);
    cap   = start && !m_frozen[w];
    m_val[w] = rd_ok;
    if (rd_ok) m_rd[w] = mq[w].pop_front();
    if (cap) begin
      m_txn[w]++;
      if (mq[w].size() < D) mq[w].push_back(r);
      else begin
        if (w == 1) begin
          void'(mq[w].pop_front());
          mq[w].push_back(r);
        end
        if (m_drop[w] < 16'hFFFF) m_drop[w]++;
      end
    end
    if (FIN) m_frozen[w] = 1'b1;
  endtask

  task automatic check_all(input int w);
    chk($sformatf("rd_valid%0d", w), 128'(rdv[w]), 128'(m_val[w]));
    chk($sformatf("rd_data%0d", w),  128'(rdd[w]), 128'(m_rd[w]));
    chk($sformatf("count%0d", w),    128'(cnt[w]), 128'(mq[w].size()));
    chk($sformatf("empty%0d", w),    128'(emp[w]), 128'(mq[w].size() == 0));
    chk($sformatf("full%0d", w),     128'(ful[w]), 128'(mq[w].size() == D));
    chk($sformatf("frozen%0d", w),   128'(frz[w]), 128'(m_frozen[w]));
    chk($sformatf("txn_cnt%0d", w),  128'(txn[w]), 128'(m_txn[w]));
    chk($sformatf("dropped%0d", w),  128'(drp[w]), 128'(m_drop[w]));
  endtask

  task automatic set_in(input logic rst, input logic st, input logic fin, input logic rde,
                        input logic [W-1:0] a, input logic [1:0] sel);
    Reset = rst; start = st; FIN = fin; rd_en = rde;
    A = a; Sel = sel;
    B = $urandom; Y = $urandom; round = 2'($urandom_range(0, 3));
    Error = 1'($urandom_range(0, 1)); Overflow = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge Clock);
    model_step(0);
    model_step(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    set_in(1, 0, 0, 0, '0, 2'd0);
    step(); step();
    chk("rst_count", 128'(cnt[0]), 128'(0));
    chk("rst_empty", 128'(emp[1]), 128'(1));

    // three captures read back in order
    set_in(0, 0, 0, 0, '0, 2'd0); step();
    set_in(0, 1, 0, 0, 32'h3F800000, 2'd0); step();
    set_in(0, 1, 0, 0, 32'h40000000, 2'd1); step();
    set_in(0, 1, 0, 0, 32'h40400000, 2'd2); step();
    set_in(0, 0, 0, 1, '0, 2'd0); step();
    chk("tp1_rd0", 128'(rdd[0][31:0]), 128'(32'h3F800000));
    chk("tp1_sel0", 128'(rdd[0][3*W+1:3*W]), 128'(0));
    step();
    chk("tp1_rd1", 128'(rdd[0][31:0]), 128'(32'h40000000));
    step();
    chk("tp1_rd2", 128'(rdd[0][31:0]), 128'(32'h40400000));
    chk("tp1_sel2", 128'(rdd[0][3*W+1:3*W]), 128'(2));
    chk("tp1_count", 128'(cnt[0]), 128'(0));
    chk("tp1_empty", 128'(emp[0]), 128'(1));
    chk("tp1_txn", 128'(txn[0]), 128'(3));

    // six captures into a four-deep buffer under both policies
    set_in(1, 0, 0, 0, '0, 2'd0); step();
    for (int unsigned i = 1; i <= 6; i++) begin
      set_in(0, 1, 0, 0, W'(i), 2'd0); step();
    end
    chk("tp2_full0", 128'(ful[0]), 128'(1));
    chk("tp2_drop0", 128'(drp[0]), 128'(2));
    chk("tp2_drop1", 128'(drp[1]), 128'(2));
    for (int unsigned i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 1, '0, 2'd0); step();
      chk("tp2_rdA0", 128'(rdd[0][31:0]), 128'(i));
      chk("tp2_rdA1", 128'(rdd[1][31:0]), 128'(i + 2));
    end

    // full buffer with coincident read and capture
    set_in(1, 0, 0, 0, '0, 2'd0); step();
    for (int unsigned i = 1; i <= 4; i++) begin
      set_in(0, 1, 0, 0, W'(i), 2'd0); step();
    end
    set_in(0, 1, 0, 1, 32'd100, 2'd3); step();
    chk("tp3_rd0", 128'(rdd[0][31:0]), 128'(1));
    chk("tp3_rd1", 128'(rdd[1][31:0]), 128'(1));
    chk("tp3_cnt0", 128'(cnt[0]), 128'(D));
    chk("tp3_cnt1", 128'(cnt[1]), 128'(D));
    chk("tp3_drop0", 128'(drp[0]), 128'(0));
    chk("tp3_drop1", 128'(drp[1]), 128'(0));
    for (int unsigned i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, '0, 2'd0); step();
    end
    chk("tp3_last0", 128'(rdd[0][31:0]), 128'(100));
    chk("tp3_last1", 128'(rdd[1][31:0]), 128'(100));

    // FIN coinciding with start, then blocked captures
    set_in(1, 0, 0, 0, '0, 2'd0); step();
    set_in(0, 1, 1, 0, 32'd7, 2'd1); step();
    set_in(0, 1, 0, 0, 32'd8, 2'd1); step();
    set_in(0, 1, 0, 0, 32'd9, 2'd1); step();
    chk("tp4_frozen", 128'(frz[0]), 128'(1));
    chk("tp4_txn", 128'(txn[0]), 128'(1));
    chk("tp4_count", 128'(cnt[1]), 128'(1));
    set_in(0, 0, 0, 1, '0, 2'd0); step();
    chk("tp4_rd", 128'(rdd[0][31:0]), 128'(7));
    chk("tp4_empty", 128'(emp[0]), 128'(1));

    // reset in the middle of a read burst
    set_in(1, 0, 0, 0, '0, 2'd0); step();
    for (int unsigned i = 1; i <= 3; i++) begin
      set_in(0, 1, 0, 0, W'(i), 2'd0); step();
    end
    set_in(0, 1, 0, 1, 32'd4, 2'd0); step();
    chk("tp5_pre", 128'(cnt[0]), 128'(3));
    set_in(1, 0, 0, 1, '0, 2'd0); step();
    chk("tp5_count", 128'(cnt[0]), 128'(0));
    chk("tp5_empty", 128'(emp[0]), 128'(1));
    chk("tp5_valid", 128'(rdv[0]), 128'(0));
    chk("tp5_txn", 128'(txn[0]), 128'(0));

    // randomized traffic with varying capture/read bias
    for (int unsigned i = 0; i < 800; i++) begin
      int unsigned pst, prd;
      pst = ((i / 100) % 2 == 0) ? 75 : 30;
      prd = 100 - pst;
      set_in(1'($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 99) < pst),
             1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 99) < prd),
             $urandom, 2'($urandom_range(0, 3)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
